// File: rtl/id_ex_register.sv
// Decode/execute pipeline boundary register.
// Holds, bubbles or loads the decoded bundle and flags load-use hazards.
module id_ex_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      idValid,
  input  logic [DATA_WIDTH-1:0]     idPc,
  input  logic [DATA_WIDTH-1:0]     idRs1Data,
  input  logic [DATA_WIDTH-1:0]     idRs2Data,
  input  logic [DATA_WIDTH-1:0]     idImm,
  input  logic [REG_ADDR_WIDTH-1:0] idRs1Addr,
  input  logic [REG_ADDR_WIDTH-1:0] idRs2Addr,
  input  logic [REG_ADDR_WIDTH-1:0] idRdAddr,
  input  logic [1:0]                idAluControl,
  input  logic [2:0]                idFunc3,
  input  logic [6:0]                idFunc7,
  input  logic                      idAluSrc,
  input  logic                      idMemRead,
  input  logic                      idMemWrite,
  input  logic                      idRegWrite,
  input  logic                      idMemToReg,
  input  logic                      idBranch,
  input  logic                      idJump,
  output logic                      hazardStall,
  output logic                      exValid,
  output logic [DATA_WIDTH-1:0]     exPc,
  output logic [DATA_WIDTH-1:0]     exRs1Data,
  output logic [DATA_WIDTH-1:0]     exRs2Data,
  output logic [DATA_WIDTH-1:0]     exImm,
  output logic [REG_ADDR_WIDTH-1:0] exRs1Addr,
  output logic [REG_ADDR_WIDTH-1:0] exRs2Addr,
  output logic [REG_ADDR_WIDTH-1:0] exRdAddr,
  output logic [1:0]                exAluControl,
  output logic [2:0]                exFunc3,
  output logic [6:0]                exFunc7,
  output logic                      exAluSrc,
  output logic                      exMemRead,
  output logic                      exMemWrite,
  output logic                      exRegWrite,
  output logic                      exMemToReg,
  output logic                      exBranch,
  output logic                      exJump
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]                alu_control;
    logic [2:0]                func3;
    logic [6:0]                func7;
    logic                      alu_src;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      branch;
    logic                      jump;
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;
  id_ex_t nxt;

  assign d.valid       = idValid;
  assign d.pc          = idPc;
  assign d.rs1_data    = idRs1Data;
  assign d.rs2_data    = idRs2Data;
  assign d.imm         = idImm;
  assign d.rs1_addr    = idRs1Addr;
  assign d.rs2_addr    = idRs2Addr;
  assign d.rd_addr     = idRdAddr;
  assign d.alu_control = idAluControl;
  assign d.func3       = idFunc3;
  assign d.func7       = idFunc7;
  assign d.alu_src     = idAluSrc;
  assign d.mem_read    = idMemRead;
  assign d.mem_write   = idMemWrite;
  assign d.reg_write   = idRegWrite;
  assign d.mem_to_reg  = idMemToReg;
  assign d.branch      = idBranch;
  assign d.jump        = idJump;

  // rs2 is compared even when the consumer does not read it
  assign hazardStall = idValid & q.valid & q.mem_read
                     & (q.rd_addr != '0)
                     & ((q.rd_addr == idRs1Addr)
                      | (q.rd_addr == idRs2Addr));

  // flush overrides a frozen pipeline; an all-zero bundle is ADD x0
  always_comb begin
    nxt = d;
    if (flush)
      nxt = '0;
    else if (stall)
      nxt = q;
    else if (hazardStall)
      nxt = '0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      q <= '0;
    else
      q <= nxt;
  end

  assign exValid      = q.valid;
  assign exPc         = q.pc;
  assign exRs1Data    = q.rs1_data;
  assign exRs2Data    = q.rs2_data;
  assign exImm        = q.imm;
  assign exRs1Addr    = q.rs1_addr;
  assign exRs2Addr    = q.rs2_addr;
  assign exRdAddr     = q.rd_addr;
  assign exAluControl = q.alu_control;
  assign exFunc3      = q.func3;
  assign exFunc7      = q.func7;
  assign exAluSrc     = q.alu_src;
  assign exMemRead    = q.mem_read;
  assign exMemWrite   = q.mem_write;
  assign exRegWrite   = q.reg_write;
  assign exMemToReg   = q.mem_to_reg;
  assign exBranch     = q.branch;
  assign exJump       = q.jump;

endmodule
